// File: rtl/imem_port_arbiter_if.sv
// BRAM-side bus of the instruction-memory port arbiter.
// The arbiter is the master; the imem macro is the slave.
interface imem_port_arbiter_if #(
  parameter int unsigned MEM_AW = 10
);
  logic              mem_en;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_en,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_en,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// Shares the single-port instruction BRAM between the fetch stage and the program loader.
// Grants are combinational from state and ld_req; the loader wins except when a running burst hits MAX_BURST.
module imem_port_arbiter #(
  parameter int unsigned MEM_AW    = 10,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       core_en,
  input  logic [31:0]                fetch_addr,
  input  logic                       fetch_kill,
  output logic                       fetch_stall,
  output logic                       fetch_valid,
  output logic [31:0]                fetch_data,
  input  logic                       ld_req,
  input  logic [31:0]                ld_addr,
  input  logic [31:0]                ld_wdata,
  output logic                       ld_ack,
  imem_port_arbiter_if.master        mem,
  input  logic                       err_clr,
  output logic                       err_misaligned,
  output logic                       err_oob
);

  localparam int unsigned      CNT_W     = 8;
  localparam logic [31:0]      NOP_INSN  = 32'h0000_0013;
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    LD   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ld_grant;
  logic             fetch_grant;
  logic             ld_oob;
  logic             fetch_misaligned;
  logic             read_pending_q;
  logic             kill_q;
  logic             unused_addr_bits;

  assign ld_oob           = |ld_addr[31:MEM_AW+2];
  assign fetch_misaligned = |fetch_addr[1:0];
  assign unused_addr_bits = ^{fetch_addr[31:MEM_AW+2], ld_addr[1:0]};

  // State and burst-count register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= BOOT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, burst count and grant decision
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ld_grant    = 1'b0;
    fetch_grant = 1'b0;
    case (state_q)
      BOOT: begin
        ld_grant = ld_req;
        cnt_d    = '0;
        if (core_en) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (ld_req) begin
          ld_grant = 1'b1;
          cnt_d    = CNT_W'(1);
          state_d  = LD;
        end else begin
          fetch_grant = 1'b1;
        end
      end
      LD: begin
        if (ld_req && (cnt_q < BURST_MAX)) begin
          ld_grant = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
        end else begin
          fetch_grant = 1'b1;
          cnt_d       = '0;
          state_d     = RUN;
        end
      end
      default: begin
        state_d = BOOT;
        cnt_d   = '0;
      end
    endcase
    // Dropping core_en returns to BOOT after this cycle's grant completes
    if ((state_q != BOOT) && !core_en) begin
      state_d = BOOT;
      cnt_d   = '0;
    end
  end

  // BRAM port and handshake drive; held at reset values while reset_n is low
  always_comb begin
    mem.mem_en    = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    ld_ack        = 1'b0;
    fetch_stall   = 1'b1;
    if (reset_n) begin
      if (ld_grant) begin
        mem.mem_en    = 1'b1;
        mem.mem_we    = !ld_oob;
        mem.mem_addr  = ld_addr[MEM_AW+1:2];
        mem.mem_wdata = ld_wdata;
        ld_ack        = 1'b1;
      end else if (fetch_grant) begin
        mem.mem_en   = 1'b1;
        mem.mem_addr = fetch_addr[MEM_AW+1:2];
        fetch_stall  = 1'b0;
      end
    end
  end

  // Tracks the read in flight and whether it was killed at issue
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_pending_q <= 1'b0;
      kill_q         <= 1'b0;
    end else begin
      read_pending_q <= fetch_grant;
      kill_q         <= fetch_grant & fetch_kill;
    end
  end

  always_comb begin
    fetch_valid = read_pending_q & !(kill_q | fetch_kill) & (state_q != BOOT) & reset_n;
    fetch_data  = fetch_valid ? mem.mem_rdata : NOP_INSN;
  end

  // Sticky error flags; a new event in the clear cycle keeps the flag set
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_oob        <= 1'b0;
      err_misaligned <= 1'b0;
    end else begin
      err_oob        <= (ld_grant & ld_oob) | (err_oob & !err_clr);
      err_misaligned <= (fetch_grant & fetch_misaligned) | (err_misaligned & !err_clr);
    end
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Self-checking bench for imem_port_arbiter: directed test-plan steps followed by
// randomized traffic, checked against a rule-level reference model and shadow memory.
module tb_imem_port_arbiter;

  localparam int unsigned MEM_AW    = 10;
  localparam int unsigned MAX_BURST = 16;
  localparam int unsigned DEPTH     = 1 << MEM_AW;
  localparam logic [31:0] NOP_INSN  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        core_en;
  logic [31:0] fetch_addr;
  logic        fetch_kill;
  logic        fetch_stall;
  logic        fetch_valid;
  logic [31:0] fetch_data;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic [31:0] ld_wdata;
  logic        ld_ack;
  logic        err_clr;
  logic        err_misaligned;
  logic        err_oob;

  int n_checks = 0;
  int n_errors = 0;

  imem_port_arbiter_if #(.MEM_AW(MEM_AW)) mem_if ();

  imem_port_arbiter #(
    .MEM_AW   (MEM_AW),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .core_en       (core_en),
    .fetch_addr    (fetch_addr),
    .fetch_kill    (fetch_kill),
    .fetch_stall   (fetch_stall),
    .fetch_valid   (fetch_valid),
    .fetch_data    (fetch_data),
    .ld_req        (ld_req),
    .ld_addr       (ld_addr),
    .ld_wdata      (ld_wdata),
    .ld_ack        (ld_ack),
    .mem           (mem_if),
    .err_clr       (err_clr),
    .err_misaligned(err_misaligned),
    .err_oob       (err_oob)
  );

  always #5 clk = ~clk;

  // Behavioural single-port BRAM with one-cycle read latency
  bit [31:0] bram [DEPTH];
  always @(posedge clk) begin
    if (mem_if.mem_en) begin
      if (mem_if.mem_we) bram[mem_if.mem_addr] <= mem_if.mem_wdata;
      else               mem_if.mem_rdata      <= bram[mem_if.mem_addr];
    end
  end

  // Reference model: running = core was enabled last cycle, burst = consecutive
  // loader wins while running, plus the read in flight and a shadow of memory.
  bit          m_run;
  int          m_burst;
  bit          m_pend;
  bit          m_pkill;
  logic [31:0] m_pdata;
  bit          m_oob;
  bit          m_mis;
  bit [31:0]   ref_mem [DEPTH];
  logic        last_ack;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  // One clock cycle with the inputs currently applied; entered and left at negedge
  task automatic cycle();
    bit          exp_ld;
    bit          exp_fetch;
    bit          exp_valid;
    bit          oob;
    int          ld_idx;
    int          f_idx;
    #1;
    exp_ld    = ld_req && (!m_run || (m_burst < MAX_BURST));
    exp_fetch = m_run && !exp_ld;
    oob       = (ld_addr >> (MEM_AW + 2)) != 32'd0;
    ld_idx    = int'((ld_addr >> 2) % DEPTH);
    f_idx     = int'((fetch_addr >> 2) % DEPTH);
    exp_valid = m_pend && !m_pkill && !fetch_kill && m_run;

    check("ld_ack",      32'(ld_ack),      32'(exp_ld));
    check("fetch_stall", 32'(fetch_stall), 32'(!exp_fetch));
    check("mem_en",      32'(mem_if.mem_en), 32'(exp_ld || exp_fetch));
    if (exp_ld) begin
      check("ld_mem_we",    32'(mem_if.mem_we),   32'(!oob));
      check("ld_mem_addr",  32'(mem_if.mem_addr), 32'(ld_idx));
      check("ld_mem_wdata", mem_if.mem_wdata,     ld_wdata);
    end else if (exp_fetch) begin
      check("rd_mem_we",   32'(mem_if.mem_we),   32'd0);
      check("rd_mem_addr", 32'(mem_if.mem_addr), 32'(f_idx));
    end
    check("fetch_valid",    32'(fetch_valid),    32'(exp_valid));
    check("fetch_data",     fetch_data,          exp_valid ? m_pdata : NOP_INSN);
    check("err_oob",        32'(err_oob),        32'(m_oob));
    check("err_misaligned", 32'(err_misaligned), 32'(m_mis));
    last_ack = ld_ack;

    @(posedge clk);
    if (exp_ld && !oob) ref_mem[ld_idx] = ld_wdata;
    m_pend  = exp_fetch;
    m_pkill = fetch_kill;
    m_pdata = ref_mem[f_idx];
    m_oob   = (exp_ld && oob) || (m_oob && !err_clr);
    m_mis   = (exp_fetch && (fetch_addr[1:0] != 2'b00)) || (m_mis && !err_clr);
    m_burst = (m_run && core_en && exp_ld) ? m_burst + 1 : 0;
    m_run   = core_en;
    @(negedge clk);
  endtask

  // Asynchronous reset: outputs must take reset values without waiting for a clock
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_ld_ack",      32'(ld_ack),           32'd0);
    check("rst_fetch_stall", 32'(fetch_stall),      32'd1);
    check("rst_fetch_valid", 32'(fetch_valid),      32'd0);
    check("rst_fetch_data",  fetch_data,            NOP_INSN);
    check("rst_mem_en",      32'(mem_if.mem_en),    32'd0);
    check("rst_mem_we",      32'(mem_if.mem_we),    32'd0);
    check("rst_mem_addr",    32'(mem_if.mem_addr),  32'd0);
    check("rst_mem_wdata",   mem_if.mem_wdata,      32'd0);
    check("rst_err_oob",     32'(err_oob),          32'd0);
    check("rst_err_mis",     32'(err_misaligned),   32'd0);
    m_run   = 1'b0;
    m_burst = 0;
    m_pend  = 1'b0;
    m_pkill = 1'b0;
    m_oob   = 1'b0;
    m_mis   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int acks;
    reset_n    = 1'b0;
    core_en    = 1'b0;
    fetch_addr = '0;
    fetch_kill = 1'b0;
    ld_req     = 1'b0;
    ld_addr    = '0;
    ld_wdata   = '0;
    err_clr    = 1'b0;
    last_ack   = 1'b0;
    @(negedge clk);
    do_reset();

    // Boot load of three words with the core held off
    for (int i = 0; i < 3; i++) begin
      ld_req   = 1'b1;
      ld_addr  = 32'(4 * i);
      ld_wdata = 32'hA0 + 32'(i);
      cycle();
    end
    ld_req = 1'b0;
    cycle();

    // Core enabled: fetch back the loaded words
    core_en = 1'b1;
    cycle();
    for (int i = 0; i < 4; i++) begin
      fetch_addr = 32'(4 * i);
      cycle();
    end

    // Loader held for 20 beats while running: one fetch slot after 16
    acks = 0;
    for (int i = 0; i < 21; i++) begin
      ld_req     = 1'b1;
      ld_addr    = 32'h100 + 32'(4 * acks);
      ld_wdata   = 32'hB000 + 32'(acks);
      fetch_addr = 32'(4 * (i % 3));
      cycle();
      if (last_ack) acks++;
    end
    check("burst_ack_count", 32'(acks), 32'd20);
    ld_req = 1'b0;
    cycle();

    // Kill in the issue cycle discards that return only
    fetch_addr = 32'h0;
    fetch_kill = 1'b1;
    cycle();
    fetch_kill = 1'b0;
    fetch_addr = 32'h4;
    cycle();
    fetch_addr = 32'h8;
    cycle();
    cycle();

    // Out-of-range loader beat and misaligned fetch
    ld_req  = 1'b1;
    ld_addr = 32'h0000_1000;
    ld_wdata = 32'hDEAD_BEEF;
    cycle();
    ld_req     = 1'b0;
    fetch_addr = 32'h6;
    cycle();
    fetch_addr = 32'h4;
    cycle();
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    cycle();
    fetch_addr = 32'h6;
    err_clr    = 1'b1;
    cycle();
    err_clr    = 1'b0;
    fetch_addr = 32'h0;
    cycle();

    // Reset in the middle of a running burst, then a fresh burst
    ld_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ld_addr  = 32'h200 + 32'(4 * i);
      ld_wdata = 32'hC000 + 32'(i);
      cycle();
    end
    do_reset();
    for (int i = 0; i < 20; i++) begin
      ld_addr  = 32'h300 + 32'(4 * i);
      ld_wdata = 32'hD000 + 32'(i);
      cycle();
    end
    ld_req = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      core_en    = ($urandom_range(0, 19) != 0);
      ld_req     = ($urandom_range(0, 9) < 5);
      ld_addr    = ($urandom_range(0, 24) == 0) ? $urandom()
                                                : 32'($urandom_range(0, 4 * DEPTH - 1));
      ld_wdata   = $urandom();
      fetch_addr = ($urandom_range(0, 9) == 0) ? $urandom()
                                               : (32'($urandom_range(0, 63)) << 2);
      fetch_kill = ($urandom_range(0, 9) == 0);
      err_clr    = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 299) == 0) do_reset();
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares the single-port synchronous instruction BRAM between the fetch stage (read every cycle) and the program loader (write bursts).
- Sits between fetch_stage and the imem macro.
- Drives fetch_stall into the PC-write logic so the PC holds while the loader owns the port.
- Supplies fetch with a valid-qualified instruction word, or NOP when the word is not valid.

Parameters:
- MEM_AW, 10: word-address width of the BRAM (depth 2^MEM_AW words).
- MAX_BURST, 16: maximum consecutive loader beats while the core runs before one fetch slot is forced; legal range 1..255.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- core_en  in  1  1 = core running; 0 = loader-exclusive (boot/reload)
- fetch_addr  in  32  byte PC from fetch stage
- fetch_kill  in  1  if_id flush; cancels the read currently in flight
- fetch_stall  out  1  1 = fetch not granted this cycle; PC must hold
- fetch_valid  out  1  fetch_data holds a valid instruction this cycle
- fetch_data  out  32  instruction word
- ld_req  in  1  loader write request, held until acked
- ld_addr  in  32  loader byte address
- ld_wdata  in  32  loader write data
- ld_ack  out  1  loader beat accepted this cycle
- mem_en  out  1  BRAM enable
- mem_we  out  1  BRAM write enable
- mem_addr  out  MEM_AW  BRAM word address
- mem_wdata  out  32  BRAM write data
- mem_rdata  in  32  BRAM read data, 1-cycle latency
- err_clr  in  1  clears sticky error flags
- err_misaligned  out  1  sticky: granted fetch with fetch_addr[1:0] != 0
- err_oob  out  1  sticky: loader address beyond the BRAM

Behaviour:
- States: BOOT, RUN, LD. Reset enters BOOT with burst count cnt = 0.
- Reset values:
  - fetch_stall = 1, fetch_valid = 0, fetch_data = 32'h00000013
  - ld_ack = 0, mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0
  - err flags = 0
- Grants are decided combinationally from state and ld_req. Exactly one requester is granted per cycle, or none.
- BOOT:
  - fetch_stall = 1.
  - If ld_req: grant the loader, with no burst limit.
  - If core_en = 1: next state RUN, cnt = 0.
- RUN:
  - If ld_req: grant the loader, fetch_stall = 1, cnt <= 1, next state LD.
  - Otherwise: grant fetch, fetch_stall = 0.
- LD:
  - If ld_req and cnt < MAX_BURST: grant the loader, cnt++.
  - Otherwise: grant fetch for one cycle, cnt <= 0, next state RUN.
  - Result: after MAX_BURST consecutive beats, fetch always gets at least one cycle.
- core_en = 0 in RUN or LD: next state BOOT. The current cycle's grant still completes.
- Loader grant:
  - mem_en = 1, mem_we = 1, mem_addr = ld_addr[MEM_AW+1:2], mem_wdata = ld_wdata, ld_ack = 1 in the same cycle.
  - ld_addr[1:0] is ignored.
  - If ld_addr[31:MEM_AW+2] != 0: ld_ack = 1 but mem_we = 0, and err_oob is set.
- Fetch grant:
  - mem_en = 1, mem_we = 0, mem_addr = fetch_addr[MEM_AW+1:2].
  - A read_pending flag is registered.
  - Upper address bits are truncated (wrap-around); no error is raised.
  - fetch_addr[1:0] != 0 sets err_misaligned; the read is still issued.
- Read return:
  - fetch_valid = read_pending & !kill_pending & (state != BOOT).
  - fetch_data = fetch_valid ? mem_rdata : 32'h00000013.
  - kill_pending is fetch_kill registered in the issue cycle, OR fetch_kill asserted in the return cycle.
- Idle cycle (no grant): mem_en = 0; the next cycle has fetch_valid = 0.
- Sticky flags:
  - Cleared by err_clr.
  - A set and err_clr in the same cycle: set wins.
- Reset asserted mid-burst: immediate return to BOOT, outputs take reset values, and any in-flight return is discarded.

Test Plan:
- Reset, core_en = 0, 3 loader beats to byte addresses 0x0, 0x4, 0x8 with data 0xA0..0xA2 -> ld_ack high on each beat in the request cycle, mem_we = 1, mem_addr = 0, 1, 2, fetch_stall = 1 throughout.
- core_en = 1, fetch_addr stepping 0x0, 0x4, 0x8 -> fetch_stall = 0, and fetch_valid with fetch_data = 0xA0, 0xA1, 0xA2 each one cycle after issue.
- RUN with ld_req held for 20 beats, MAX_BURST = 16 -> beats 1..16 acked, cycle 17 fetch granted (fetch_stall = 0), beats 17..20 acked afterwards, fetch_valid only after the fetch slot.
- fetch_kill pulsed in an issue cycle -> fetch_valid = 0 next cycle, fetch_data = 0x00000013, following fetch unaffected.
- Loader address 0x0000_1000 with MEM_AW = 10 -> ld_ack = 1, mem_we = 0, err_oob = 1 until err_clr; fetch_addr 0x6 -> err_misaligned = 1.
- reset_n low during an LD burst at cnt = 5 -> state BOOT, fetch_stall = 1, ld_ack = 0 immediately; after release, loader beats accepted with cnt restarted.
